// File: rtl/flight_sequencer.sv
// flight_sequencer: sequences a multirotor through IDLE, ESC calibration, sensor offset capture, arming, flight and landing.
// Latency: throttles are registered; in FLY they follow ctrl_throttles one clock later, clamped to THR_LIMIT.
// Backpressure: none; IMU and height strobes are single-cycle and are always accepted while they are used.
//
// Ports:
//   clock, reset                : single clock domain, synchronous active-high reset
//   fly, idle                   : operator requests; idle wins when both are high
//   imu_new_data, roll/pitch/yaw: IMU sample strobe and signed angles
//   srf05_new_data, distance    : height sample strobe and reading
//   ctrl_throttles              : flight controller command, motor 0 in the LSBs
//   imu_start, srf05_start      : sensor enables
//   motors_start, motors_idle   : motor controller control
//   throttles                   : registered motor commands
//   offset_*                    : averaged sensor offsets captured in INIT
//   state, fault                : current state encoding, sticky fault flag
module flight_sequencer #(
  parameter int NUM_MOTORS    = 4,
  parameter int THR_W         = 8,
  parameter int DATA_W        = 16,
  parameter int DIST_W        = 15,
  parameter int AVG_LOG2      = 4,
  parameter bit CALIBRATE_ESC = 1'b0,
  parameter int TICK_CYCLES   = 50_000_000,
  parameter int TIMEOUT_TICKS = 2,
  parameter int CAL_TICKS     = 3,
  parameter int RAMP_CYCLES   = 500_000,
  parameter int THR_LIMIT     = 2**THR_W - 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         fly,
  input  logic                         idle,
  input  logic                         imu_new_data,
  input  logic [DATA_W-1:0]            roll,
  input  logic [DATA_W-1:0]            pitch,
  input  logic [DATA_W-1:0]            yaw,
  input  logic                         srf05_new_data,
  input  logic [DIST_W-1:0]            distance,
  input  logic [NUM_MOTORS*THR_W-1:0]  ctrl_throttles,
  output logic                         imu_start,
  output logic                         srf05_start,
  output logic                         motors_start,
  output logic                         motors_idle,
  output logic [NUM_MOTORS*THR_W-1:0]  throttles,
  output logic [DATA_W-1:0]            offset_roll,
  output logic [DATA_W-1:0]            offset_pitch,
  output logic [DATA_W-1:0]            offset_yaw,
  output logic [DIST_W-1:0]            offset_distance,
  output logic [2:0]                   state,
  output logic                         fault
);

  localparam int ACC_W  = DATA_W + AVG_LOG2;
  localparam int CNT_W  = AVG_LOG2 + 1;
  localparam int TICK_W = $clog2(TICK_CYCLES + 1);
  localparam int PH_W   = $clog2(2 * CAL_TICKS + 2);
  localparam int WD_W   = $clog2(TIMEOUT_TICKS + 2);
  localparam int RAMP_W = $clog2(RAMP_CYCLES + 1);
  localparam logic [THR_W-1:0] LIMIT = THR_W'(THR_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CAL   = 3'd1,
    S_INIT  = 3'd2,
    S_ARMED = 3'd3,
    S_FLY   = 3'd4,
    S_LAND  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic [TICK_W-1:0] tick_cnt;
  logic [PH_W-1:0]   phase_cnt;
  logic [PH_W-1:0]   phase_nx;
  logic [WD_W-1:0]   imu_wd;
  logic [WD_W-1:0]   srf_wd;
  logic [RAMP_W-1:0] ramp_cnt;
  logic [ACC_W-1:0]  acc_roll;
  logic [ACC_W-1:0]  acc_pitch;
  logic [ACC_W-1:0]  acc_yaw;
  logic [CNT_W-1:0]  imu_cnt;
  logic              have_dist;
  logic [DIST_W-1:0] dist_q;
  logic [NUM_MOTORS*THR_W-1:0] thr_d;

  logic tick;
  logic state_chg;
  logic imu_trip;
  logic srf_trip;
  logic wd_trip;
  logic ramp;
  logic imu_full;
  logic init_done;
  logic cal_done;

  assign state = cur_state;

  assign tick      = (tick_cnt == TICK_W'(TICK_CYCLES - 1));
  assign state_chg = (nxt_state != cur_state);
  assign imu_trip  = tick && !imu_new_data && (imu_wd == WD_W'(TIMEOUT_TICKS - 1));
  assign srf_trip  = tick && !srf05_new_data && (srf_wd == WD_W'(TIMEOUT_TICKS - 1));
  assign wd_trip   = ((cur_state == S_INIT) && (imu_trip || srf_trip)) ||
                     ((cur_state == S_FLY) && imu_trip);
  assign ramp      = (cur_state == S_LAND) && (ramp_cnt == RAMP_W'(RAMP_CYCLES - 1));
  assign imu_full  = (imu_cnt == CNT_W'(1 << AVG_LOG2));
  assign init_done = imu_full && have_dist;
  assign cal_done  = (CAL_TICKS == 0) ||
                     (tick && (phase_cnt == PH_W'(2 * CAL_TICKS - 1)));

  function automatic logic [THR_W-1:0] clamp_thr(input logic [THR_W-1:0] v);
    return (v > LIMIT) ? LIMIT : v;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; idle is checked before fly everywhere it matters
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE:  if (!idle && fly) nxt_state = CALIBRATE_ESC ? S_CAL : S_INIT;
      S_CAL: begin
        if (idle)          nxt_state = S_IDLE;
        else if (cal_done) nxt_state = S_INIT;
      end
      S_INIT: begin
        if (idle)           nxt_state = S_IDLE;
        else if (wd_trip)   nxt_state = S_FAULT;
        else if (init_done) nxt_state = S_ARMED;
      end
      S_ARMED: begin
        if (idle)     nxt_state = S_IDLE;
        else if (fly) nxt_state = S_FLY;
      end
      S_FLY:   if (idle || wd_trip) nxt_state = S_LAND;
      S_LAND:  if (throttles == '0) nxt_state = fault ? S_FAULT : S_IDLE;
      S_FAULT: nxt_state = S_FAULT;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Output decode; sensors stay enabled from INIT through LAND for the controller
  always_comb begin
    imu_start    = 1'b0;
    srf05_start  = 1'b0;
    motors_start = 1'b0;
    motors_idle  = 1'b0;
    case (cur_state)
      S_CAL:   motors_start = 1'b1;
      S_INIT: begin
        imu_start   = 1'b1;
        srf05_start = 1'b1;
      end
      S_ARMED: begin
        imu_start    = 1'b1;
        srf05_start  = 1'b1;
        motors_start = 1'b1;
        motors_idle  = 1'b1;
      end
      S_FLY, S_LAND: begin
        imu_start    = 1'b1;
        srf05_start  = 1'b1;
        motors_start = 1'b1;
      end
      S_FAULT: motors_idle = 1'b1;
      default: ;
    endcase
  end

  // Tick timebase, restarted on every state change so phase timing is exact
  always_ff @(posedge clock) begin
    if (reset || state_chg || tick) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || state_chg)              phase_cnt <= '0;
    else if ((cur_state == S_CAL) && tick) phase_cnt <= phase_cnt + 1'b1;
  end

  // Phase count as it will be after this edge, so the CAL throttle level
  // lines up with the state register instead of lagging it by a clock.
  always_comb begin
    phase_nx = phase_cnt;
    if (state_chg)                         phase_nx = '0;
    else if ((cur_state == S_CAL) && tick) phase_nx = phase_cnt + 1'b1;
  end

  // Sensor watchdogs: count ticks since the last strobe, only while relevant
  always_ff @(posedge clock) begin
    if (reset || state_chg || !((cur_state == S_INIT) || (cur_state == S_FLY))) begin
      imu_wd <= '0;
      srf_wd <= '0;
    end else begin
      if (imu_new_data) imu_wd <= '0;
      else if (tick)    imu_wd <= imu_wd + 1'b1;
      if (srf05_new_data) srf_wd <= '0;
      else if (tick)      srf_wd <= srf_wd + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)                 fault <= 1'b0;
    else if (wd_trip && !idle) fault <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset || (cur_state != S_LAND) || ramp) ramp_cnt <= '0;
    else                                        ramp_cnt <= ramp_cnt + 1'b1;
  end

  // Throttle next value is keyed on the next state so each phase's level
  // appears on the same edge the state changes.
  always_comb begin
    thr_d = '0;
    case (nxt_state)
      S_CAL: if (phase_nx < PH_W'(CAL_TICKS)) thr_d = '1;
      S_FLY: begin
        for (int m = 0; m < NUM_MOTORS; m++)
          thr_d[m*THR_W +: THR_W] = clamp_thr(ctrl_throttles[m*THR_W +: THR_W]);
      end
      S_LAND: begin
        thr_d = throttles;
        if ((cur_state == S_LAND) && ramp) begin
          for (int m = 0; m < NUM_MOTORS; m++)
            if (throttles[m*THR_W +: THR_W] != '0)
              thr_d[m*THR_W +: THR_W] = throttles[m*THR_W +: THR_W] - 1'b1;
        end
      end
      default: thr_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) throttles <= '0;
    else       throttles <= thr_d;
  end

  // Offset capture: accumulators live only while in INIT; offsets persist
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_roll        <= '0;
      acc_pitch       <= '0;
      acc_yaw         <= '0;
      imu_cnt         <= '0;
      have_dist       <= 1'b0;
      dist_q          <= '0;
      offset_roll     <= '0;
      offset_pitch    <= '0;
      offset_yaw      <= '0;
      offset_distance <= '0;
    end else begin
      if (cur_state != S_INIT) begin
        acc_roll  <= '0;
        acc_pitch <= '0;
        acc_yaw   <= '0;
        imu_cnt   <= '0;
        have_dist <= 1'b0;
      end else begin
        if (imu_new_data && !imu_full) begin
          acc_roll  <= acc_roll  + {{AVG_LOG2{roll[DATA_W-1]}},  roll};
          acc_pitch <= acc_pitch + {{AVG_LOG2{pitch[DATA_W-1]}}, pitch};
          acc_yaw   <= acc_yaw   + {{AVG_LOG2{yaw[DATA_W-1]}},   yaw};
          imu_cnt   <= imu_cnt + 1'b1;
        end
        if (srf05_new_data) begin
          dist_q    <= distance;
          have_dist <= 1'b1;
        end
      end
      // Upper DATA_W bits of the accumulator are the arithmetic shift by AVG_LOG2
      if ((cur_state == S_INIT) && (nxt_state == S_ARMED)) begin
        offset_roll     <= acc_roll[ACC_W-1:AVG_LOG2];
        offset_pitch    <= acc_pitch[ACC_W-1:AVG_LOG2];
        offset_yaw      <= acc_yaw[ACC_W-1:AVG_LOG2];
        offset_distance <= dist_q;
      end
    end
  end

endmodule
